// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: core operation codes,
// keypad codes and the key sequencer state encoding.
package calc_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ENTER = 3'd1;
  localparam logic [2:0] OP_PLUS  = 3'd2;
  localparam logic [2:0] OP_MINUS = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_ESC   = 3'd6;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_PLUS      = 4'd10;
  localparam logic [3:0] KEY_MINUS     = 4'd11;
  localparam logic [3:0] KEY_MULT      = 4'd12;
  localparam logic [3:0] KEY_DIV       = 4'd13;
  localparam logic [3:0] KEY_ENTER     = 4'd14;
  localparam logic [3:0] KEY_ESC       = 4'd15;

  typedef enum logic [2:0] {
    ST_ENTRY_A,
    ST_OP_ISSUE,
    ST_ENTRY_B,
    ST_EQ_ISSUE,
    ST_WAIT_DONE,
    ST_SHOW,
    ST_ERR,
    ST_ESC_ISSUE
  } seq_state_t;

  function automatic logic [2:0] key_to_op(input logic [3:0] key);
    case (key)
      KEY_PLUS:  key_to_op = OP_PLUS;
      KEY_MINUS: key_to_op = OP_MINUS;
      KEY_MULT:  key_to_op = OP_MULT;
      KEY_DIV:   key_to_op = OP_DIV;
      default:   key_to_op = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_digit_shift.sv
// Four-digit BCD entry register: digits shift in from the units end, the
// count caps entry at MAX_DIGITS, and load restarts entry with one digit.
module calc_digit_shift #(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] key,
  output logic [7:0] dig_0,
  output logic [7:0] dig_1,
  output logic [7:0] dig_2,
  output logic [7:0] dig_3,
  output logic       all_zero
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [CNT_W-1:0] count_q;
  logic [3:0]       d0_q, d1_q, d2_q, d3_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      d3_q    <= 4'd0;
      count_q <= '0;
    end else if (load) begin
      d0_q    <= key;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      d3_q    <= 4'd0;
      count_q <= CNT_W'(1);
    end else if (shift && (count_q < CNT_W'(MAX_DIGITS))) begin
      d3_q    <= d2_q;
      d2_q    <= d1_q;
      d1_q    <= d0_q;
      d0_q    <= key;
      count_q <= count_q + 1'b1;
    end
  end

  assign dig_0    = {4'd0, d0_q};
  assign dig_1    = {4'd0, d1_q};
  assign dig_2    = {4'd0, d2_q};
  assign dig_3    = {4'd0, d3_q};
  assign all_zero = ~|{d3_q, d2_q, d1_q, d0_q};

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad-to-core sequencer: collects operand A, operator, operand B, issues
// single-cycle operation pulses and tracks result, timeout and error status.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_DIGITS     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        cal_done,
  input  logic [27:0] cal_ans,
  output logic [7:0]  dig_0,
  output logic [7:0]  dig_1,
  output logic [7:0]  dig_2,
  output logic [7:0]  dig_3,
  output logic [2:0]  operation,
  output logic        disp_sel,
  output logic        ans_ovf,
  output logic        err,
  output logic        busy,
  output seq_state_t  state_dbg
);

  localparam int          CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [27:0] ANS_MAX = 28'd9999;

  // key_valid is a one-cycle strobe with no back-pressure: a key is consumed
  // in the cycle it is valid or lost, so keys during ISSUE states are dropped.
  seq_state_t       state_q, state_nxt;
  logic [2:0]       op_q, op_nxt, operation_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             dig_shift, dig_clear, dig_load, digits_zero;
  logic             is_digit, is_op, is_enter, is_esc;

  assign is_digit = key_valid && (key_code <= KEY_MAX_DIGIT);
  assign is_op    = key_valid && (key_code >= KEY_PLUS) && (key_code <= KEY_DIV);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign is_esc   = key_valid && (key_code == KEY_ESC);

  calc_digit_shift #(.MAX_DIGITS(MAX_DIGITS)) u_digits (
    .clk      (clk),
    .reset    (reset),
    .shift    (dig_shift),
    .clear    (dig_clear),
    .load     (dig_load),
    .key      (key_code),
    .dig_0    (dig_0),
    .dig_1    (dig_1),
    .dig_2    (dig_2),
    .dig_3    (dig_3),
    .all_zero (digits_zero)
  );

  always_comb begin
    state_nxt     = state_q;
    op_nxt        = op_q;
    cnt_nxt       = cnt_q;
    dig_shift     = 1'b0;
    dig_clear     = 1'b0;
    dig_load      = 1'b0;
    operation_nxt = OP_NONE;
    case (state_q)
      ST_ENTRY_A: begin
        if (is_digit) begin
          dig_shift = 1'b1;
        end else if (is_op) begin
          op_nxt    = key_to_op(key_code);
          state_nxt = ST_OP_ISSUE;
        end else if (is_esc) begin
          dig_clear = 1'b1;
          state_nxt = ST_ESC_ISSUE;
        end
      end
      // Digits stay on the bus through the pulse so the core captures operand A.
      ST_OP_ISSUE: begin
        dig_clear = 1'b1;
        state_nxt = ST_ENTRY_B;
      end
      ST_ENTRY_B: begin
        if (is_digit) begin
          dig_shift = 1'b1;
        end else if (is_enter) begin
          state_nxt = (op_q == OP_DIV && digits_zero) ? ST_ERR : ST_EQ_ISSUE;
        end else if (is_esc) begin
          dig_clear = 1'b1;
          state_nxt = ST_ESC_ISSUE;
        end
      end
      ST_EQ_ISSUE: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = ST_WAIT_DONE;
      end
      // cnt_q holds the number of cycles elapsed since the ENTER pulse.
      ST_WAIT_DONE: begin
        cnt_nxt = cnt_q + 1'b1;
        if (is_esc) begin
          dig_clear = 1'b1;
          state_nxt = ST_ESC_ISSUE;
        end else if (cal_done) begin
          state_nxt = ST_SHOW;
        end else if (cnt_nxt >= CNT_W'(TIMEOUT_CYCLES)) begin
          state_nxt = ST_ERR;
        end
      end
      ST_SHOW: begin
        if (is_esc) begin
          dig_clear = 1'b1;
          state_nxt = ST_ESC_ISSUE;
        end else if (is_digit) begin
          dig_load  = 1'b1;
          state_nxt = ST_ESC_ISSUE;
        end
      end
      ST_ERR: begin
        if (is_esc) begin
          dig_clear = 1'b1;
          state_nxt = ST_ESC_ISSUE;
        end
      end
      ST_ESC_ISSUE: state_nxt = ST_ENTRY_A;
      default:      state_nxt = ST_ENTRY_A;
    endcase

    case (state_nxt)
      ST_OP_ISSUE:  operation_nxt = op_nxt;
      ST_EQ_ISSUE:  operation_nxt = OP_ENTER;
      ST_ESC_ISSUE: operation_nxt = OP_ESC;
      default:      operation_nxt = OP_NONE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ENTRY_A;
      op_q      <= OP_NONE;
      cnt_q     <= '0;
      operation <= OP_NONE;
      disp_sel  <= 1'b0;
      ans_ovf   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      cnt_q     <= cnt_nxt;
      operation <= operation_nxt;
      disp_sel  <= (state_nxt == ST_SHOW);
      ans_ovf   <= (state_nxt == ST_SHOW) && (cal_ans > ANS_MAX);
      err       <= (state_nxt == ST_ERR);
      busy      <= (state_nxt == ST_WAIT_DONE);
    end
  end

  assign state_dbg = state_q;

endmodule
